// File: rtl/synaptic_injector.sv
// Event-driven synaptic fan-out: per spiking source, walks its fan-out list and does I[target] += w.
// Build option: define SYN_INJ_SAT_EN to saturate the current accumulation instead of wrapping.
module synaptic_injector #(
    parameter int N          = 4096,
    parameter int ADDRW      = 12,
    parameter int PACK_WIDTH = 8,
    parameter int FANOUT     = 4,
    parameter int SYNW       = ADDRW + $clog2(FANOUT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    output logic                  o_done,
    input  logic                  i_spike_valid,
    input  logic [PACK_WIDTH-1:0] i_spike_data,
    output logic                  o_spike_ready,
    output logic [SYNW-1:0]       o_syn_addr,
    input  logic [31:0]           i_syn_data,
    output logic [ADDRW-1:0]      o_curr_addr,
    output logic                  o_curr_we,
    output logic [31:0]           o_curr_din,
    input  logic [31:0]           i_curr_data
);

    localparam int NWORDS = (N + PACK_WIDTH - 1) / PACK_WIDTH;
    localparam int CNTW   = $clog2(NWORDS + 1);
    localparam int KW     = (FANOUT > 1) ? $clog2(FANOUT) : 1;
    localparam int FSH    = $clog2(FANOUT);
    localparam int BW     = (PACK_WIDTH > 1) ? $clog2(PACK_WIDTH) : 1;

    // state      | meaning
    // IDLE       | waiting for i_start
    // WAIT_WORD  | accepting the next packed spike word
    // SCAN       | pick lowest pending spike, or finish the word / pass
    // SYN_RD     | drive synapse address src*FANOUT+k
    // SYN_WAIT   | synapse memory latency
    // SYN_LAT    | capture synapse entry, skip if invalid
    // CUR_RD     | drive current address = target
    // CUR_WAIT   | current memory latency
    // CUR_WR     | write back I[target] + weight
    // NEXT       | advance k through the fan-out list
    // DONE       | pass complete, hold until i_start drops
    typedef enum logic [3:0] {
        S_IDLE, S_WAIT_WORD, S_SCAN, S_SYN_RD, S_SYN_WAIT, S_SYN_LAT,
        S_CUR_RD, S_CUR_WAIT, S_CUR_WR, S_NEXT, S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [CNTW-1:0]       r_word_cnt;
    logic [PACK_WIDTH-1:0] r_pend;
    logic [ADDRW-1:0]      r_base;
    logic [ADDRW-1:0]      r_src;
    logic [KW-1:0]         r_k;
    logic [15:0]           r_weight;
    logic [ADDRW-1:0]      r_target;
    logic [SYNW-1:0]       r_syn_addr;
    logic [ADDRW-1:0]      r_curr_addr;
    logic                  r_ready;
    logic                  r_done;

    logic                  w_handshake;
    logic [PACK_WIDTH-1:0] w_mask;
    logic [BW-1:0]         w_low_idx;
    logic                  w_k_last;
    logic [31:0]           w_wext;
    logic [31:0]           w_sum;
    logic [31:0]           w_result;
    logic                  w_unused;

    assign w_handshake = (r_state == S_WAIT_WORD) && r_ready && i_spike_valid;
    assign w_k_last    = (r_k == KW'(FANOUT - 1));
    assign w_unused    = ^i_syn_data[14:0];

    // Spike bits past the last neuron in the final word are dropped.
    always_comb begin
        w_mask = '0;
        for (int k = 0; k < PACK_WIDTH; k++)
            w_mask[k] = ((int'(r_word_cnt) * PACK_WIDTH + k) < N);
    end

    always_comb begin
        w_low_idx = '0;
        for (int i = PACK_WIDTH - 1; i >= 0; i--)
            if (r_pend[i]) w_low_idx = BW'(i);
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (i_start) w_next = S_WAIT_WORD;
            S_WAIT_WORD: if (w_handshake) w_next = S_SCAN;
            S_SCAN: begin
                if (r_pend != '0)
                    w_next = S_SYN_RD;
                else if (r_word_cnt == CNTW'(NWORDS))
                    w_next = S_DONE;
                else
                    w_next = S_WAIT_WORD;
            end
            S_SYN_RD:    w_next = S_SYN_WAIT;
            S_SYN_WAIT:  w_next = S_SYN_LAT;
            S_SYN_LAT:   w_next = i_syn_data[15] ? S_CUR_RD : S_NEXT;
            S_CUR_RD:    w_next = S_CUR_WAIT;
            S_CUR_WAIT:  w_next = S_CUR_WR;
            S_CUR_WR:    w_next = S_NEXT;
            S_NEXT:      w_next = w_k_last ? S_SCAN : S_SYN_RD;
            S_DONE:      if (!i_start) w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_word_cnt  <= '0;
            r_pend      <= '0;
            r_base      <= '0;
            r_src       <= '0;
            r_k         <= '0;
            r_weight    <= '0;
            r_target    <= '0;
            r_syn_addr  <= '0;
            r_curr_addr <= '0;
            r_ready     <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ready <= (r_state == S_WAIT_WORD) && !w_handshake;
            r_done  <= (w_next == S_DONE);
            if (r_state == S_IDLE && i_start)
                r_word_cnt <= '0;
            if (w_handshake) begin
                r_pend     <= i_spike_data & w_mask;
                r_base     <= ADDRW'(int'(r_word_cnt) * PACK_WIDTH);
                r_word_cnt <= r_word_cnt + 1'b1;
            end
            if (r_state == S_SCAN && r_pend != '0) begin
                r_src  <= r_base + ADDRW'(w_low_idx);
                r_pend <= r_pend & (r_pend - 1'b1);
                r_k    <= '0;
            end
            if (r_state == S_SYN_RD)
                r_syn_addr <= (SYNW'(r_src) << FSH) | SYNW'(r_k);
            if (r_state == S_SYN_LAT) begin
                r_weight <= i_syn_data[31:16];
                r_target <= i_syn_data[ADDRW-1:0];
            end
            if (r_state == S_CUR_RD)
                r_curr_addr <= r_target;
            if (r_state == S_NEXT)
                r_k <= r_k + 1'b1;
        end
    end

    assign w_wext = {{16{r_weight[15]}}, r_weight};
    assign w_sum  = i_curr_data + w_wext;

`ifdef SYN_INJ_SAT_EN
    always_comb begin
        w_result = w_sum;
        if (!i_curr_data[31] && !w_wext[31] && w_sum[31])
            w_result = 32'h7FFF_FFFF;
        else if (i_curr_data[31] && w_wext[31] && !w_sum[31])
            w_result = 32'h8000_0000;
    end
`else
    assign w_result = w_sum;
`endif

    // Write strobe decodes straight from state so reset removes it immediately.
    assign o_curr_we     = (r_state == S_CUR_WR);
    assign o_curr_din    = o_curr_we ? w_result : 32'h0;
    assign o_curr_addr   = r_curr_addr;
    assign o_syn_addr    = r_syn_addr;
    assign o_spike_ready = r_ready;
    assign o_done        = r_done;

endmodule

// File: tb/tb_synaptic_injector.sv
// Directed bench for synaptic_injector (N=12, 8-bit words, fan-out 2) with behavioural memories.
module tb_synaptic_injector;
    localparam int N = 12, ADDRW = 4, PW = 8, FANOUT = 2, SYNW = 5;

`ifdef SYN_INJ_SAT_EN
    localparam logic [31:0] EXP_POS_OVF = 32'h7FFF_FFFF;
    localparam logic [31:0] EXP_NEG_OVF = 32'h8000_0000;
`else
    localparam logic [31:0] EXP_POS_OVF = 32'h8000_7FEF;
    localparam logic [31:0] EXP_NEG_OVF = 32'h7FFF_8010;
`endif

    logic             clk, rst, i_start, o_done, i_spike_valid, o_spike_ready;
    logic [PW-1:0]    i_spike_data;
    logic [SYNW-1:0]  o_syn_addr;
    logic [31:0]      i_syn_data, i_curr_data, o_curr_din;
    logic [ADDRW-1:0] o_curr_addr;
    logic             o_curr_we;

    synaptic_injector #(.N(N), .ADDRW(ADDRW), .PACK_WIDTH(PW), .FANOUT(FANOUT)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .o_done(o_done),
        .i_spike_valid(i_spike_valid), .i_spike_data(i_spike_data),
        .o_spike_ready(o_spike_ready), .o_syn_addr(o_syn_addr),
        .i_syn_data(i_syn_data), .o_curr_addr(o_curr_addr), .o_curr_we(o_curr_we),
        .o_curr_din(o_curr_din), .i_curr_data(i_curr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] syn_mem [0:31];
    logic [31:0] curr_mem [0:15];
    logic [31:0] syn_q, curr_q;
    logic        ld_en, clr_en;
    logic [3:0]  ld_addr;
    logic [31:0] ld_data;
    int          n_wr = 0;

    always @(posedge clk) begin
        syn_q  <= syn_mem[o_syn_addr];
        curr_q <= curr_mem[o_curr_addr];
        if (clr_en) begin
            for (int i = 0; i < 16; i++) curr_mem[i] <= 32'h0;
        end else if (ld_en) begin
            curr_mem[ld_addr] <= ld_data;
        end
        if (o_curr_we) begin
            curr_mem[o_curr_addr] <= o_curr_din;
            n_wr++;
        end
    end
    assign i_syn_data  = syn_q;
    assign i_curr_data = curr_q;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [15:0] w, input logic v, input int t);
        return {w, v, 11'b0, 4'(t)};
    endfunction

    task automatic clear_mems();
        for (int i = 0; i < 32; i++) syn_mem[i] = 32'h0;
        @(negedge clk) clr_en = 1'b1;
        @(negedge clk) clr_en = 1'b0;
    endtask

    task automatic set_curr(input int a, input logic [31:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = 4'(a); ld_data = d;
        @(negedge clk) ld_en = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the handshake edge.
    task automatic send_word(input logic [PW-1:0] d, input int dly);
        int n;
        repeat (dly) @(negedge clk);
        i_spike_valid = 1'b1;
        i_spike_data  = d;
        n = 0;
        while (!o_spike_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("spike_ready", {31'b0, o_spike_ready}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        i_spike_valid = 1'b0;
    endtask

    task automatic run_pass(input logic [PW-1:0] w0, input logic [PW-1:0] w1, input int dly);
        int n;
        @(negedge clk) i_start = 1'b1;
        send_word(w0, dly);
        send_word(w1, dly);
        n = 0;
        while (!o_done && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("done_rise", {31'b0, o_done}, 32'h1);
    endtask

    task automatic end_pass();
        i_start = 1'b0;
        repeat (2) @(negedge clk);
        check("done_clear", {31'b0, o_done}, 32'h0);
    endtask

    typedef struct {
        int          src;
        logic [31:0] e0, e1;
        int          it;
        logic [31:0] iv;
        int          ta;
        logic [31:0] ea;
        int          tb;
        logic [31:0] eb;
        int          nwr;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [PW-1:0]   w0, w1;
        logic [SYNW-1:0] addr_before;
        int              wr0;

        vecs[0] = '{0,  mk(16'd100, 1, 3),   mk(16'hFFD8, 1, 5), 0, 32'h0,         3, 32'd100,     5, 32'hFFFF_FFD8, 2};
        vecs[1] = '{9,  mk(16'd5, 1, 7),     mk(16'd5, 1, 7),    7, 32'd10,        7, 32'd20,      7, 32'd20,        2};
        vecs[2] = '{4,  mk(16'd50, 0, 6),    mk(16'hFFFD, 1, 1), 1, 32'd7,         6, 32'd0,       1, 32'd4,         1};
        vecs[3] = '{2,  mk(16'h7FFF, 1, 2),  mk(16'd9, 0, 2),    2, 32'h7FFF_FFF0, 2, EXP_POS_OVF, 0, 32'h0,         1};
        vecs[4] = '{11, mk(16'hFFFF, 1, 0),  mk(16'h8000, 1, 0), 0, 32'h0,         0, 32'hFFFF_7FFF, 0, 32'hFFFF_7FFF, 2};
        vecs[5] = '{8,  mk(16'd7, 0, 3),     mk(16'd9, 0, 4),    0, 32'h0,         3, 32'h0,       4, 32'h0,         0};
        vecs[6] = '{5,  mk(16'h8000, 1, 9),  mk(16'd1, 0, 9),    9, 32'h8000_0010, 9, EXP_NEG_OVF, 0, 32'h0,         1};

        rst = 1'b1; i_start = 1'b0; i_spike_valid = 1'b0; i_spike_data = '0;
        ld_en = 1'b0; clr_en = 1'b0; ld_addr = '0; ld_data = '0;
        for (int i = 0; i < 32; i++) syn_mem[i] = 32'h0;
        #23;
        check("rst_done",      {31'b0, o_done}, 32'h0);
        check("rst_ready",     {31'b0, o_spike_ready}, 32'h0);
        check("rst_we",        {31'b0, o_curr_we}, 32'h0);
        check("rst_syn_addr",  {27'b0, o_syn_addr}, 32'h0);
        check("rst_curr_addr", {28'b0, o_curr_addr}, 32'h0);
        check("rst_curr_din",  o_curr_din, 32'h0);
        @(negedge clk) rst = 1'b0;

        for (int v = 0; v < 7; v++) begin
            clear_mems();
            syn_mem[vecs[v].src*2]     = vecs[v].e0;
            syn_mem[vecs[v].src*2 + 1] = vecs[v].e1;
            set_curr(vecs[v].it, vecs[v].iv);
            w0 = '0; w1 = '0;
            if (vecs[v].src < 8) w0[vecs[v].src] = 1'b1;
            else                 w1[vecs[v].src - 8] = 1'b1;
            wr0 = n_wr;
            run_pass(w0, w1, 0);
            check($sformatf("vec%0d_Ia", v), curr_mem[vecs[v].ta], vecs[v].ea);
            check($sformatf("vec%0d_Ib", v), curr_mem[vecs[v].tb], vecs[v].eb);
            check($sformatf("vec%0d_writes", v), 32'(n_wr - wr0), 32'(vecs[v].nwr));
            end_pass();
        end

        // All-zero words: no synapse or current activity at all.
        clear_mems();
        syn_mem[0] = mk(16'd1, 1, 1);
        addr_before = o_syn_addr;
        wr0 = n_wr;
        run_pass(8'h00, 8'h00, 0);
        check("zero_writes",   32'(n_wr - wr0), 32'h0);
        check("zero_syn_addr", {27'b0, o_syn_addr}, {27'b0, addr_before});
        check("zero_I1",       curr_mem[1], 32'h0);
        end_pass();

        // Backpressure plus tail masking: sources 12..15 lie beyond N and must be ignored.
        clear_mems();
        for (int s = 8; s < 12; s++) syn_mem[s*2] = mk(16'd1, 1, 10);
        for (int a = 24; a < 32; a++) syn_mem[a] = mk(16'd1, 1, 15);
        wr0 = n_wr;
        run_pass(8'h00, 8'hFF, 5);
        check("tail_I10",    curr_mem[10], 32'd4);
        check("tail_I15",    curr_mem[15], 32'd0);
        check("tail_writes", 32'(n_wr - wr0), 32'd4);
        repeat (5) @(negedge clk);
        check("done_held", {31'b0, o_done}, 32'h1);
        end_pass();

        // Reset asserted while waiting on the current memory read.
        clear_mems();
        syn_mem[0] = mk(16'd100, 1, 3);
        @(negedge clk) i_start = 1'b1;
        send_word(8'h01, 0);
        repeat (5) @(negedge clk);
        check("rmid_curr_addr", {28'b0, o_curr_addr}, 32'd3);
        wr0 = n_wr;
        rst = 1'b1;
        #1;
        check("rmid_we", {31'b0, o_curr_we}, 32'h0);
        i_start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("rmid_writes", 32'(n_wr - wr0), 32'h0);
        check("rmid_I3",     curr_mem[3], 32'h0);
        check("rmid_ready",  {31'b0, o_spike_ready}, 32'h0);
        check("rmid_done",   {31'b0, o_done}, 32'h0);

        wr0 = n_wr;
        run_pass(8'h01, 8'h00, 0);
        check("fresh_I3",     curr_mem[3], 32'd100);
        check("fresh_writes", 32'(n_wr - wr0), 32'd1);
        end_pass();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
